instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, number of instruction FIFO entries; legal values are powers of two, 2 to 16.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ena  input  1  block enable; when low, no push, no pop, state held.
REQ-005 Port: in_valid  input  1  producer presents an instruction-field set.
REQ-006 Port: in_ready  output  1  encoder accepts fields this cycle.
REQ-007 Port: opcode  input  3  ALU opcode field (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 CMP, 110/111 NOP).
REQ-008 Port: reg_sel  input  1  destination register select field.
REQ-009 Port: operand  input  4  immediate operand field.
REQ-010 Port: instr_out  output  8  encoded instruction at FIFO head, to decoder instr_in.
REQ-011 Port: out_valid  output  1  instr_out holds a valid instruction.
REQ-012 Port: out_ready  input  1  consumer takes instr_out this cycle.
REQ-013 Port: count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: illegal  output  1  one-cycle pulse: last accepted push carried opcode 110 or 111.

Function
REQ-015 Encoding SHALL be instr = {opcode[2:0], reg_sel, operand[3:0]}: bits [7:5] opcode, bit [4] reg_sel, bits [3:0] operand.
REQ-016 in_ready SHALL equal ena AND (count < DEPTH), combinationally.
REQ-017 Push SHALL occur on a rising edge where in_valid AND in_ready; the encoded byte is written at the tail and the tail pointer advances, wrapping modulo DEPTH.
REQ-018 out_valid SHALL equal ena AND (count > 0).
REQ-019 instr_out SHALL show the head entry when count > 0 and 8'h00 when count = 0.
REQ-020 Pop SHALL occur on a rising edge where out_valid AND out_ready; the head pointer advances, wrapping modulo DEPTH.
REQ-021 Push-to-output latency SHALL be one cycle: a byte pushed into an empty FIFO appears on instr_out with out_valid high in the next cycle.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-023 When full (count = DEPTH), in_ready SHALL be low even if a pop occurs in the same cycle; no push that cycle.
REQ-024 When empty, out_ready SHALL have no effect; count SHALL never underflow or exceed DEPTH.
REQ-025 When ena is low, pointers, count and storage SHALL hold, in_ready and out_valid SHALL be low, and illegal SHALL be low.
REQ-026 Opcodes 110/111 SHALL be encoded and queued unmodified; illegal SHALL be high for exactly the cycle after such a push, otherwise low.
REQ-027 Delivery order SHALL be strict FIFO; no entry is dropped, duplicated or reordered.

Reset
REQ-028 While reset is high, head, tail and count SHALL be 0 and in_ready, out_valid, illegal SHALL be 0, and instr_out SHALL be 8'h00, independent of clock.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; after release the FIFO is empty and in_ready returns high in the first cycle with ena high.
REQ-030 Storage contents need not be cleared by reset; they SHALL never be visible while count = 0.

Verification
REQ-031 Encode: ena=1, push opcode=000, reg_sel=0, operand=0011 into an empty FIFO -> next cycle instr_out=8'h03, out_valid=1, count=1.
REQ-032 Fill/full: push 8'h21, 8'h45, 8'h6F, 8'hA7 with out_ready=0 -> count=4, in_ready=0; a fifth in_valid is not accepted; then drain with out_ready=1 -> bytes appear in order 21,45,6F,A7, then out_valid=0, instr_out=8'h00.
REQ-033 Simultaneous: count=2, push and pop in the same cycle -> count stays 2, next head is the old second entry; at count=4 with pop and in_valid -> no push, count=3.
REQ-034 Wrap-around: 10 sequential push/pop pairs with DEPTH=4 -> all 10 bytes delivered in order, no loss.
REQ-035 Illegal/ena: push opcode=111, operand=0000 -> instr_out=8'hE0, illegal high one cycle; with ena=0 and in_valid=1 -> no push, out_valid=0, count unchanged.
REQ-036 Reset mid-stream: count=3, assert reset between clock edges -> count=0, out_valid=0, instr_out=8'h00 immediately; after release a new push of 8'hB5 is the first byte delivered.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Producer/consumer handshake bundle for the instruction encoder FIFO.
// The producer side drives the fields; the consumer side takes instr_out.
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic       reg_sel;
  logic [3:0] operand;
  logic [7:0] instr_out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid, opcode, reg_sel, operand, out_ready,
    input  in_ready, instr_out, out_valid
  );

  modport slave (
    input  in_valid, opcode, reg_sel, operand, out_ready,
    output in_ready, instr_out, out_valid
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs {opcode, reg_sel, operand} into one byte and queues it in a
// DEPTH-entry FIFO; flags opcodes 110/111 with a one-cycle illegal pulse.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ena,
  instr_encoder_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] head, tail;
  logic [AW:0]   cnt;
  logic [7:0]    mem [DEPTH];
  logic          ill_q;
  logic          push, pop, nonempty;

  assign nonempty = (cnt != '0);

  // Handshakes are gated by reset so they read low while reset is held,
  // regardless of the clock.
  assign bus.in_ready  = ena & ~reset & (cnt < FULL);
  assign bus.out_valid = ena & ~reset & nonempty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Stale storage is masked whenever the FIFO is empty.
  assign bus.instr_out = nonempty ? mem[head] : 8'h00;
  assign count         = cnt;
  assign illegal       = ill_q & ena;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      ill_q <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ill_q <= push & (bus.opcode[2:1] == 2'b11);
    end
  end

  // Storage carries no reset; it is only observable through a valid head.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= {bus.opcode, bus.reg_sel, bus.operand};
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: accepted pushes queue a hand-computed byte, a monitor
// pops and compares on every consumer handshake.
module tb_instr_encoder;
  logic       clock = 1'b0;
  logic       reset;
  logic       ena;
  logic [2:0] count;
  logic       illegal;
  logic [7:0] pend_exp;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  instr_encoder_if bus();

  instr_encoder #(.DEPTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .ena     (ena),
    .bus     (bus),
    .count   (count),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Input side: log the expected byte whenever the DUT accepts a push.
  always @(negedge clock) begin
    if (!reset && bus.in_valid && bus.in_ready) exp_q.push_back(pend_exp);
  end

  // Output side: every consumer handshake must match the queue head.
  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected nothing", bus.instr_out);
      end else begin
        chk("fifo_order", {24'h0, bus.instr_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic push1(input logic [2:0] op, input logic rs, input logic [3:0] od,
                       input logic [7:0] e);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.reg_sel  = rs;
    bus.operand  = od;
    pend_exp     = e;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] wrap_tab [10];
    wrap_tab = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A};
    reset = 1'b1; ena = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = 3'd0; bus.reg_sel = 1'b0; bus.operand = 4'd0;
    pend_exp = 8'h00;
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instr_out", bus.instr_out, 8'h00);
    @(posedge clock); #3 reset = 1'b0;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);

    // basic encode
    push1(3'b000, 1'b0, 4'b0011, 8'h03);
    chk("enc_instr_out", bus.instr_out, 8'h03);
    chk("enc_out_valid", bus.out_valid, 1);
    chk("enc_count", count, 1);
    chk("enc_illegal", illegal, 0);
    drain(1);
    chk("enc_empty_valid", bus.out_valid, 0);

    // fill to full, reject fifth, drain in order
    push1(3'b001, 1'b0, 4'b0001, 8'h21);
    push1(3'b010, 1'b0, 4'b0101, 8'h45);
    push1(3'b011, 1'b0, 4'b1111, 8'h6F);
    push1(3'b101, 1'b0, 4'b0111, 8'hA7);
    chk("full_count", count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    push1(3'b000, 1'b1, 4'b1001, 8'h19);
    chk("full_reject_count", count, 4);
    drain(4);
    chk("drained_out_valid", bus.out_valid, 0);
    chk("drained_instr_out", bus.instr_out, 8'h00);
    chk("drained_count", count, 0);
    drain(1);
    chk("underflow_count", count, 0);

    // simultaneous push/pop
    push1(3'b000, 1'b1, 4'b0001, 8'h11);
    push1(3'b001, 1'b0, 4'b0010, 8'h22);
    bus.out_ready = 1'b1;
    push1(3'b001, 1'b1, 4'b0011, 8'h33);
    bus.out_ready = 1'b0;
    chk("simul_count", count, 2);
    chk("simul_head", bus.instr_out, 8'h22);
    push1(3'b010, 1'b0, 4'b0100, 8'h44);
    push1(3'b010, 1'b1, 4'b0101, 8'h55);
    chk("simul_full_count", count, 4);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1 chk("full_pop_in_ready", bus.in_ready, 0);
    push1(3'b011, 1'b0, 4'b0110, 8'h66);
    bus.out_ready = 1'b0;
    chk("full_pop_count", count, 3);
    drain(3);

    // wrap-around
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = wrap_tab[i];
      push1(b[7:5], b[4], b[3:0], b);
    end
    bus.out_ready = 1'b0;
    chk("wrap_count", count, 1);
    drain(1);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // illegal opcode and enable gating
    push1(3'b111, 1'b0, 4'b0000, 8'hE0);
    chk("ill_instr_out", bus.instr_out, 8'hE0);
    chk("ill_pulse", illegal, 1);
    @(posedge clock); #1;
    chk("ill_clear", illegal, 0);
    ena = 1'b0;
    #1 chk("ena0_out_valid", bus.out_valid, 0);
    chk("ena0_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    push1(3'b011, 1'b1, 4'b0111, 8'h77);
    bus.out_ready = 1'b0;
    chk("ena0_count", count, 1);
    ena = 1'b1;
    #1 chk("ena1_head", bus.instr_out, 8'hE0);
    drain(1);

    // reset mid-stream
    push1(3'b100, 1'b0, 4'b0001, 8'h81);
    push1(3'b100, 1'b1, 4'b0010, 8'h92);
    push1(3'b101, 1'b0, 4'b0011, 8'hA3);
    chk("pre_rst_count", count, 3);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_instr_out", bus.instr_out, 8'h00);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clock); #1 reset = 1'b0;
    #1 chk("rel_in_ready", bus.in_ready, 1);
    push1(3'b101, 1'b1, 4'b0101, 8'hB5);
    chk("rel_head", bus.instr_out, 8'hB5);
    drain(1);
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
